// File: rtl/dispatch_pkg.sv
// Shared types and constants for the command dispatcher: FSM states,
// response codes, opcode field position and the opcode legality lookup.
package dispatch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_RESP      = 3'd3,
    ST_WAIT_TX   = 3'd4
  } state_t;

  localparam logic [7:0] RESP_ACK = 8'hA5;
  localparam logic [7:0] RESP_NAK = 8'h5A;
  localparam logic [7:0] RESP_TMO = 8'hEE;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;

  function automatic logic opc_legal(input logic [15:0] mask, input logic [3:0] opc);
    return mask[opc];
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Small circular command buffer with a combinational head. A push into a full
// buffer is accepted when a pop happens in the same cycle.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE_W    = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   cnt_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign empty     = (cnt_r == {(AW+1){1'b0}});
  assign full      = (cnt_r == FULL_CNT);
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);
  assign dout      = mem_r[rd_ptr_r];
  assign cnt       = cnt_r;

  // Storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {W{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      cnt_r    <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + ONE_W[AW-1:0];
      end
      if (do_pop_s) rd_ptr_r <= rd_ptr_r + ONE_W[AW-1:0];
      case ({do_push_s, do_pop_s})
        2'b10:   cnt_r <= cnt_r + ONE_W;
        2'b01:   cnt_r <= cnt_r - ONE_W;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: rtl/cmd_dispatch.sv
// Takes commands from the UART wrapper, queues them, issues one at a time to
// the executor and returns one response byte per command (ACK/NAK/timeout).
module cmd_dispatch
  import dispatch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] OPC_MASK = 16'h00FF,
  parameter int          TMO_W    = 20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_rdy,
  input  logic [15:0]            cmd,
  output logic                   clr_cmd_rdy,
  output logic                   trmt,
  output logic [7:0]             resp,
  input  logic                   tx_done,
  output logic                   exe_vld,
  output logic [15:0]            exe_cmd,
  input  logic                   exe_rdy,
  input  logic                   exe_done,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [TMO_W-1:0] WDOG_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};
  localparam logic [TMO_W-1:0] WDOG_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  state_t           state_r;
  logic [TMO_W-1:0] wdog_r;
  logic             nak_pend_r;
  logic             clr_r;
  logic             trmt_r;
  logic             exe_vld_r;
  logic [7:0]       resp_r;
  logic [15:0]      exe_cmd_r;

  logic             take_s;
  logic             legal_s;
  logic             push_s;
  logic             pop_s;
  logic             nak_set_s;
  logic             full_s;
  logic             empty_s;
  logic [15:0]      head_s;
  logic [CW-1:0]    cnt_s;

  // Ignore cmd_rdy while our clear pulse is out so one command is never taken twice
  assign take_s    = cmd_rdy && !clr_r;
  assign legal_s   = opc_legal(OPC_MASK, cmd[OPC_MSB:OPC_LSB]);
  assign pop_s     = (state_r == ST_IDLE) && !nak_pend_r && !empty_s;
  assign push_s    = take_s && legal_s && (!full_s || pop_s);
  assign nak_set_s = take_s && !legal_s && !nak_pend_r;

  cmd_fifo #(.DEPTH(DEPTH), .W(16)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .din   (cmd),
    .dout  (head_s),
    .full  (full_s),
    .empty (empty_s),
    .cnt   (cnt_s)
  );

  // Intake: clear pulse and pending-NAK flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_r      <= 1'b0;
      nak_pend_r <= 1'b0;
    end else begin
      clr_r <= push_s || nak_set_s;
      if (nak_set_s) nak_pend_r <= 1'b1;
      else if ((state_r == ST_RESP) && (resp_r == RESP_NAK)) nak_pend_r <= 1'b0;
    end
  end

  // Dispatch FSM with executor watchdog; trmt is raised on leaving RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      wdog_r    <= {TMO_W{1'b0}};
      trmt_r    <= 1'b0;
      exe_vld_r <= 1'b0;
      exe_cmd_r <= 16'h0000;
      resp_r    <= 8'h00;
    end else begin
      trmt_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (nak_pend_r) begin
            resp_r  <= RESP_NAK;
            state_r <= ST_RESP;
          end else if (!empty_s) begin
            exe_cmd_r <= head_s;
            exe_vld_r <= 1'b1;
            state_r   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (exe_rdy) begin
            exe_vld_r <= 1'b0;
            wdog_r    <= {TMO_W{1'b0}};
            state_r   <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (exe_done) begin
            resp_r  <= RESP_ACK;
            state_r <= ST_RESP;
          end else if (wdog_r == WDOG_LAST) begin
            resp_r  <= RESP_TMO;
            state_r <= ST_RESP;
          end
          wdog_r <= wdog_r + WDOG_ONE;
        end
        ST_RESP: begin
          trmt_r  <= 1'b1;
          state_r <= ST_WAIT_TX;
        end
        ST_WAIT_TX: begin
          if (tx_done) state_r <= ST_IDLE;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign clr_cmd_rdy = clr_r;
  assign trmt        = trmt_r;
  assign resp        = resp_r;
  assign exe_vld     = exe_vld_r;
  assign exe_cmd     = exe_cmd_r;
  assign busy        = (state_r != ST_IDLE) || !empty_s;
  assign fifo_cnt    = cnt_s;

endmodule
